mb_shift_reg: RTL and testbench

MB_SHIFT_REG -- requirements
Module: mb_shift_reg

---
 rtl/mb_shift_reg.sv | 134 +++++++++++++
 tb/tb_mb_shift_reg.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mb_shift_reg.sv
// mb_shift_reg: WIDTH-bit bidirectional shift register with parallel load,
// synchronous reset/set, clock enable, optional rotate mode and a saturating
// shift counter. Every output is driven straight from a flop, so input
// activity between edges can never reach Q, Qn, Cnt or Done.
module mb_shift_reg #(
  parameter int WIDTH  = 8,
  parameter bit ROTATE = 1'b0,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             Cp,
  input  logic             Rn,
  input  logic             Sn,
  input  logic             En,
  input  logic [1:0]       S,
  input  logic [WIDTH-1:0] D,
  input  logic             SR_in,
  input  logic             SL_in,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [CW-1:0]    Cnt,
  output logic             Done
);

  // Operating modes carried on S.
  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_MAX  = CW'(WIDTH);
  localparam logic [WIDTH-1:0] Q_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] Q_ONES   = {WIDTH{1'b1}};

  // Counter increment that sticks at WIDTH once reached.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] value);
    logic [CW-1:0] result;
    if (value >= CNT_MAX) begin
      result = CNT_MAX;
    end else begin
      result = value + {{(CW-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

  // Registered state and registered output decodes.
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] qn_r;
  logic [CW-1:0]    cnt_r;
  logic             done_r;

  // Next-state values computed from the current state and sampled inputs.
  logic [WIDTH-1:0] q_next_s;
  logic [CW-1:0]    cnt_next_s;
  logic             right_fill_s;
  logic             left_fill_s;
  mode_e            mode_s;

  assign mode_s = mode_e'(S);

  // Bits entering the register on a shift: serial inputs, or wrap-around.
  always_comb begin
    right_fill_s = SR_in;
    left_fill_s  = SL_in;
    if (ROTATE) begin
      right_fill_s = q_r[0];
      left_fill_s  = q_r[WIDTH-1];
    end else begin
      right_fill_s = SR_in;
      left_fill_s  = SL_in;
    end
  end

  // Next-state decode: set beats enable, enable beats mode. Reset is applied
  // in the state register itself so it dominates everything here.
  always_comb begin
    q_next_s   = q_r;
    cnt_next_s = cnt_r;
    if (!Sn) begin
      q_next_s   = Q_ONES;
      cnt_next_s = CNT_ZERO;
    end else if (!En) begin
      q_next_s   = q_r;
      cnt_next_s = cnt_r;
    end else begin
      case (mode_s)
        MODE_HOLD: begin
          q_next_s   = q_r;
          cnt_next_s = cnt_r;
        end
        MODE_RIGHT: begin
          q_next_s   = {right_fill_s, q_r[WIDTH-1:1]};
          cnt_next_s = sat_inc(cnt_r);
        end
        MODE_LEFT: begin
          q_next_s   = {q_r[WIDTH-2:0], left_fill_s};
          cnt_next_s = sat_inc(cnt_r);
        end
        MODE_LOAD: begin
          q_next_s   = D;
          cnt_next_s = CNT_ZERO;
        end
        default: begin
          q_next_s   = q_r;
          cnt_next_s = cnt_r;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset; Qn and Done are
  // registered alongside Q and Cnt so they change only on the clock edge.
  always_ff @(posedge Cp) begin
    if (!Rn) begin
      q_r    <= Q_ZERO;
      qn_r   <= Q_ONES;
      cnt_r  <= CNT_ZERO;
      done_r <= 1'b0;
    end else begin
      q_r    <= q_next_s;
      qn_r   <= ~q_next_s;
      cnt_r  <= cnt_next_s;
      done_r <= (cnt_next_s == CNT_MAX);
    end
  end

  assign Q    = q_r;
  assign Qn   = qn_r;
  assign Cnt  = cnt_r;
  assign Done = done_r;

endmodule

// File: tb/tb_mb_shift_reg.sv
// Self-checking bench for mb_shift_reg: three instances (8-bit shift,
// 8-bit rotate, 4-bit shift) share one stimulus stream and are compared
// every cycle against an arithmetic reference model; directed sequences
// additionally pin values by hand-computed literals.
module tb_mb_shift_reg;

  logic       cp;
  logic       rn, sn, en, sr_in, sl_in;
  logic [1:0] s;
  logic [7:0] d;

  logic [7:0] q8, qn8, q8r, qn8r;
  logic [3:0] cnt8, cnt8r;
  logic       done8, done8r;
  logic [3:0] q4, qn4;
  logic [2:0] cnt4;
  logic       done4;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state per instance: 0 = 8-bit shift, 1 = 8-bit rotate, 2 = 4-bit.
  int mq[3];
  int mc[3];
  bit mvalid = 1'b0;

  mb_shift_reg #(.WIDTH(8), .ROTATE(1'b0)) u_s8 (
    .Cp(cp), .Rn(rn), .Sn(sn), .En(en), .S(s), .D(d), .SR_in(sr_in), .SL_in(sl_in),
    .Q(q8), .Qn(qn8), .Cnt(cnt8), .Done(done8)
  );

  mb_shift_reg #(.WIDTH(8), .ROTATE(1'b1)) u_r8 (
    .Cp(cp), .Rn(rn), .Sn(sn), .En(en), .S(s), .D(d), .SR_in(sr_in), .SL_in(sl_in),
    .Q(q8r), .Qn(qn8r), .Cnt(cnt8r), .Done(done8r)
  );

  mb_shift_reg #(.WIDTH(4), .ROTATE(1'b0)) u_s4 (
    .Cp(cp), .Rn(rn), .Sn(sn), .En(en), .S(s), .D(d[3:0]), .SR_in(sr_in), .SL_in(sl_in),
    .Q(q4), .Qn(qn4), .Cnt(cnt4), .Done(done4)
  );

  initial begin
    cp = 1'b0;
    forever #5 cp = ~cp;
  end

  function automatic int width_of(int k);
    return (k == 2) ? 4 : 8;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arithmetic view of the register, updated on each rising edge.
  always @(posedge cp) begin
    for (int k = 0; k < 3; k++) begin
      int w, mask, fill;
      w    = width_of(k);
      mask = (1 << w) - 1;
      if (!rn) begin
        mq[k] = 0;
        mc[k] = 0;
      end else if (!sn) begin
        mq[k] = mask;
        mc[k] = 0;
      end else if (en) begin
        case (s)
          2'b01: begin
            fill  = (k == 1) ? (mq[k] & 1) : int'(sr_in);
            mq[k] = (mq[k] >> 1) | (fill << (w - 1));
            mc[k] = (mc[k] + 1 > w) ? w : mc[k] + 1;
          end
          2'b10: begin
            fill  = (k == 1) ? ((mq[k] >> (w - 1)) & 1) : int'(sl_in);
            mq[k] = ((mq[k] << 1) | fill) & mask;
            mc[k] = (mc[k] + 1 > w) ? w : mc[k] + 1;
          end
          2'b11: begin
            mq[k] = int'(d) & mask;
            mc[k] = 0;
          end
          default: ;
        endcase
      end
    end
    if (!rn) mvalid = 1'b1;
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge cp) begin
    if (mvalid) begin
      check("s8_q",     q8,     mq[0]);
      check("s8_qn",    qn8,    (~mq[0]) & 32'hFF);
      check("s8_cnt",   cnt8,   mc[0]);
      check("s8_done",  done8,  (mc[0] == 8) ? 1 : 0);
      check("r8_q",     q8r,    mq[1]);
      check("r8_qn",    qn8r,   (~mq[1]) & 32'hFF);
      check("r8_cnt",   cnt8r,  mc[1]);
      check("r8_done",  done8r, (mc[1] == 8) ? 1 : 0);
      check("s4_q",     q4,     mq[2]);
      check("s4_qn",    qn4,    (~mq[2]) & 32'hF);
      check("s4_cnt",   cnt4,   mc[2]);
      check("s4_done",  done4,  (mc[2] == 4) ? 1 : 0);
    end
  end

  // One rising edge, then return at the following falling edge.
  task automatic step();
    @(posedge cp);
    @(negedge cp);
  endtask

  initial begin
    rn = 1'b0; sn = 1'b1; en = 1'b0; s = 2'b00; d = 8'h00; sr_in = 1'b0; sl_in = 1'b0;

    // Reset, then load A5.
    step();
    check("rst_q", q8, 8'h00);
    check("rst_qn", qn8, 8'hFF);
    check("rst_cnt", cnt8, 4'd0);
    check("rst_done", done8, 1'b0);
    rn = 1'b1; en = 1'b1; s = 2'b11; d = 8'hA5;
    step();
    check("load_q", q8, 8'hA5);
    check("load_qn", qn8, 8'h5A);
    check("load_cnt", cnt8, 4'd0);
    check("load_done", done8, 1'b0);

    // Right shift of ones into a cleared register until Done, plus one more.
    d = 8'h00;
    step();
    s = 2'b01; sr_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      int i4;
      step();
      i4 = (i > 4) ? 4 : i;
      check("rsh_q", q8, (32'hFF00 >> i) & 32'hFF);
      check("rsh_cnt", cnt8, i);
      check("rsh_done", done8, (i == 8) ? 1 : 0);
      check("w4_q", q4, (32'hF0 >> i4) & 32'hF);
      check("w4_cnt", cnt4, i4);
      check("w4_done", done4, (i >= 4) ? 1 : 0);
    end
    sr_in = 1'b0;
    step();
    check("rsh9_q", q8, 8'h7F);
    check("rsh9_cnt", cnt8, 4'd8);
    check("rsh9_done", done8, 1'b1);
    check("w4_9_q", q4, 4'h7);
    check("w4_9_cnt", cnt4, 3'd4);

    // Rotate: serial inputs toggled with no effect.
    s = 2'b11; d = 8'h81;
    step();
    check("rot_load", q8r, 8'h81);
    s = 2'b10; sl_in = 1'b0; sr_in = 1'b1;
    step();
    check("rot_left", q8r, 8'h03);
    s = 2'b01; sl_in = 1'b1; sr_in = 1'b0;
    step();
    check("rot_r1", q8r, 8'h81);
    sl_in = 1'b0; sr_in = 1'b1;
    step();
    check("rot_r2", q8r, 8'hC0);
    check("rot_cnt", cnt8r, 4'd3);

    // Priority: reset over set over enable.
    rn = 1'b0; sn = 1'b0; s = 2'b11; d = 8'h55;
    step();
    check("pri_rst", q8, 8'h00);
    rn = 1'b1; sn = 1'b0; en = 1'b0;
    step();
    check("pri_set_q", q8, 8'hFF);
    check("pri_set_cnt", cnt8, 4'd0);
    sn = 1'b1; en = 1'b0; s = 2'b01;
    step();
    check("pri_en_q", q8, 8'hFF);
    check("pri_en_cnt", cnt8, 4'd0);

    // Reset in the middle of a shift sequence.
    en = 1'b1; s = 2'b11; d = 8'h3C;
    step();
    s = 2'b10; sl_in = 1'b0;
    repeat (3) step();
    check("mid_q", q8, 8'hE0);
    check("mid_cnt", cnt8, 4'd3);
    rn = 1'b0;
    step();
    check("mid_rst_q", q8, 8'h00);
    check("mid_rst_cnt", cnt8, 4'd0);
    rn = 1'b1; s = 2'b10; sl_in = 1'b1;
    step();
    check("mid_after_q", q8, 8'h01);
    check("mid_after_cnt", cnt8, 4'd1);

    // Hold via mode and via enable.
    s = 2'b00;
    repeat (4) step();
    check("hold_q", q8, 8'h01);
    check("hold_cnt", cnt8, 4'd1);
    en = 1'b0; s = 2'b01;
    repeat (4) step();
    check("en_hold_q", q8, 8'h01);
    check("en_hold_cnt", cnt8, 4'd1);

    // Randomized traffic, with extra input wiggles between edges.
    for (int n = 0; n < 3000; n++) begin
      rn    = ($urandom_range(0, 31) != 0);
      sn    = ($urandom_range(0, 15) != 0);
      en    = ($urandom_range(0, 3) != 0);
      s     = 2'($urandom);
      d     = 8'($urandom);
      sr_in = 1'($urandom);
      sl_in = 1'($urandom);
      if (n % 7 == 0) begin
        logic [1:0] s_keep;
        logic [7:0] d_keep;
        s_keep = s; d_keep = d;
        #1 s = 2'($urandom); d = 8'($urandom);
        #1 s = s_keep; d = d_keep;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
